// File: rtl/req_ack_pkg.sv
// req_ack_pkg: shared state encoding, outcome codes and default sizing for the request/ack arbiter
package req_ack_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  localparam logic OUT_OK = 1'b0;
  localparam logic OUT_ERR = 1'b1;
  localparam int DEF_NREQ = 4;
  localparam int DEF_DW = 32;
  localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner, searching upward from last+1 modulo NREQ
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic                    any,
  output logic [$clog2(NREQ)-1:0] idx
);
  localparam int GW = $clog2(NREQ);
  logic [GW-1:0] c;
  // Walk candidates from farthest to nearest so the nearest requester overwrites last
  always_comb begin
    idx = last;
    c = '0;
    for (int i = NREQ; i >= 1; i--) begin
      c = GW'((int'(last) + i) % NREQ);
      if (req[c]) idx = c;
    end
    any = |req;
  end
endmodule

// File: rtl/req_ack_arbiter.sv
// req_ack_arbiter: round-robin arbiter funnelling NREQ requesters onto one req/ack bus with timeout
module req_ack_arbiter import req_ack_pkg::*; #(
  parameter int NREQ = DEF_NREQ,
  parameter int DW = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_done,
  output logic [NREQ-1:0]         req_err,
  output logic                    bus_req,
  output logic [DW-1:0]           bus_data,
  input  logic                    bus_ack,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    spurious_ack
);
  localparam int GW = $clog2(NREQ);
  state_t state, nxt;
  logic [7:0] cnt;
  logic [GW-1:0] last_grant, pick;
  logic any, out, finish;
  rr_pick #(.NREQ(NREQ)) u_pick (.req(req_valid), .last(last_grant), .any(any), .idx(pick));
  // Ack on the expiry cycle still counts as success
  always_comb begin
    finish = bus_ack || cnt == 8'(TIMEOUT - 1);
    out = bus_ack ? OUT_OK : OUT_ERR;
    nxt = state == S_IDLE  ? (any ? S_ISSUE : S_IDLE) :
          state == S_ISSUE ? S_WAIT :
          state == S_WAIT  ? (finish ? S_DONE : S_WAIT) : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      last_grant <= GW'(NREQ - 1);
      grant_id <= '0;
      bus_data <= '0;
      bus_req <= 1'b0;
      busy <= 1'b0;
      req_done <= '0;
      req_err <= '0;
      spurious_ack <= 1'b0;
    end else begin
      state <= nxt;
      busy <= nxt != S_IDLE;
      bus_req <= nxt == S_ISSUE;
      cnt <= state == S_WAIT ? cnt + 8'd1 : '0;
      if (state == S_IDLE && any) begin
        grant_id <= pick;
        last_grant <= pick;
        bus_data <= req_data[pick*DW +: DW];
      end
      req_done <= (state == S_WAIT && finish && out == OUT_OK) ? {{(NREQ-1){1'b0}}, 1'b1} << grant_id : '0;
      req_err <= (state == S_WAIT && finish && out == OUT_ERR) ? {{(NREQ-1){1'b0}}, 1'b1} << grant_id : '0;
      spurious_ack <= spurious_ack | (bus_ack && state != S_WAIT);
    end
  end
endmodule

// File: tb/tb_req_ack_arbiter.sv
// tb_req_ack_arbiter: directed scoreboard bench for req_ack_arbiter
module tb_req_ack_arbiter;
  localparam int NREQ = 4;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0] req_done, req_err;
  logic bus_req, bus_ack = 1'b0, busy, spurious_ack;
  logic [DW-1:0] bus_data;
  logic [1:0] grant_id;
  typedef struct packed {logic [1:0] g; logic [31:0] d;} iss_t;
  typedef struct packed {logic [3:0] done; logic [3:0] err;} rsp_t;
  iss_t q_iss[$];
  rsp_t q_rsp[$];
  logic [31:0] dv [4] = '{32'h0000feed, 32'h12345678, 32'hcafebabe, 32'hdeadbeef};
  int n_cmp = 0, n_err = 0, cyc = 0;
  always #5 clk = ~clk;
  req_ack_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_done(req_done), .req_err(req_err), .bus_req(bus_req), .bus_data(bus_data),
    .bus_ack(bus_ack), .grant_id(grant_id), .busy(busy), .spurious_ack(spurious_ack)
  );
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    iss_t ei;
    rsp_t er;
    @(posedge clk);
    #1;
    cyc++;
    if (bus_req) begin
      chk("issue_expected", 64'(q_iss.size() > 0), 1);
      if (q_iss.size() > 0) begin
        ei = q_iss.pop_front();
        chk("issue_grant", 64'(grant_id), 64'(ei.g));
        chk("issue_data", 64'(bus_data), 64'(ei.d));
      end
    end
    if ((req_done | req_err) != '0) begin
      chk("resp_expected", 64'(q_rsp.size() > 0), 1);
      chk("resp_single", 64'($countones({req_done, req_err})), 1);
      if (q_rsp.size() > 0) begin
        er = q_rsp.pop_front();
        chk("resp_done", 64'(req_done), 64'(er.done));
        chk("resp_err", 64'(req_err), 64'(er.err));
      end
    end
  endtask
  task automatic expect_req(int g, logic [3:0] done, logic [3:0] err, bit with_rsp);
    q_iss.push_back('{g: 2'(g), d: dv[g]});
    if (with_rsp) q_rsp.push_back('{done: done, err: err});
  endtask
  task automatic wait_issue(output int at);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus_req && n < 10);
    chk("issue_seen", 64'(bus_req), 1);
    at = cyc;
  endtask
  initial begin
    int at, prev, n;
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = dv[i];
    tick();
    tick();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_grant", 64'(grant_id), 0);
    chk("rst_bus_req", 64'(bus_req), 0);
    chk("rst_bus_data", 64'(bus_data), 0);
    chk("rst_done_err", 64'({req_done, req_err}), 0);
    chk("rst_spurious", 64'(spurious_ack), 0);
    reset = 1'b0;
    // single request, ack two cycles after bus_req
    req_valid = 4'b0001;
    expect_req(0, 4'b0001, 4'b0000, 1);
    wait_issue(at);
    chk("t1_data", 64'(bus_data), 64'h0000feed);
    tick();
    tick();
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    req_valid = '0;
    chk("t1_done", 64'(req_done), 64'b0001);
    tick();
    chk("t1_idle", 64'(busy), 0);
    // all four held: round-robin 0,1,2,3,0 with 4-cycle spacing
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      expect_req(k % 4, 4'(1 << (k % 4)), 4'b0000, 1);
      prev = at;
      wait_issue(at);
      if (k > 0) chk("rr_spacing", 64'(at - prev), 4);
      tick();
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      if (k == 4) req_valid = '0;
    end
    tick();
    // requester 2, no ack: timeout after 16 WAIT cycles
    req_valid = 4'b0100;
    expect_req(2, 4'b0000, 4'b0100, 1);
    wait_issue(at);
    n = 0;
    do begin
      tick();
      n++;
    end while (req_err == '0 && req_done == '0 && n < 40);
    req_valid = '0;
    chk("t3_latency", 64'(n), 17);
    chk("t3_err", 64'(req_err), 64'b0100);
    chk("t3_no_done", 64'(req_done), 0);
    tick();
    // ack on the expiry cycle wins
    req_valid = 4'b0010;
    expect_req(1, 4'b0010, 4'b0000, 1);
    wait_issue(at);
    repeat (16) tick();
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    req_valid = '0;
    chk("t4_done", 64'(req_done), 64'b0010);
    chk("t4_no_err", 64'(req_err), 0);
    tick();
    // ack while idle
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("t5_spurious", 64'(spurious_ack), 1);
    repeat (3) tick();
    chk("t5_sticky", 64'(spurious_ack), 1);
    chk("t5_grant", 64'(grant_id), 1);
    chk("t5_busy", 64'(busy), 0);
    // reset during WAIT aborts silently
    req_valid = 4'b1000;
    expect_req(3, 4'b0000, 4'b0000, 0);
    wait_issue(at);
    tick();
    tick();
    chk("t6_in_wait", 64'(busy), 1);
    reset = 1'b1;
    tick();
    chk("t6_busy", 64'(busy), 0);
    chk("t6_grant", 64'(grant_id), 0);
    chk("t6_bus", 64'({bus_req, bus_data}), 0);
    chk("t6_done_err", 64'({req_done, req_err}), 0);
    chk("t6_spurious", 64'(spurious_ack), 0);
    req_valid = 4'b1001;
    tick();
    reset = 1'b0;
    expect_req(0, 4'b0001, 4'b0000, 1);
    wait_issue(at);
    tick();
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    req_valid = '0;
    tick();
    chk("q_iss_empty", 64'(q_iss.size()), 0);
    chk("q_rsp_empty", 64'(q_rsp.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
